mod_table_rw: RTL and testbench

- Runtime-writable RNS modulus table for the bootstrapping datapath. Successor to the fixed modulus ROM.
- Holds up to DEPTH odd moduli of up to MOD_W bits, each with its Montgomery constant n0' = -m^-1 mod 2^64.
- A sequential Newton/Hensel engine computes n0' on every write. NUM_RD registered read ports feed the parallel Montgomery multiplier lanes.

---
 rtl/mod_table_pkg.sv | 33 +++
 rtl/mod_table_rw_mont_n0_engine.sv | 110 +++++++++++
 rtl/mod_table_rw.sv | 153 +++++++++++++++
 tb/tb_mod_table_rw.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mod_table_pkg.sv
// Shared types and constants for the runtime-writable RNS modulus table.
// MOD_TABLE_DEFAULT_INIT_EN selects whether reset preloads the DEFAULT_* entries.
package mod_table_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ERR    = 3'd1,
        MUL_A  = 3'd2,
        MUL_B  = 3'd3,
        COMMIT = 3'd4
    } n0_state_e;

    // Starting from x = m gives 3 correct bits; 5 doublings reach 96 >= 64.
    localparam int NEWTON_ITERS = 5;

    localparam int DEFAULT_N = 4;

    localparam logic [63:0] DEFAULT_MOD [DEFAULT_N] = '{
        64'd1, 64'd3, 64'd5, 64'd7
    };

    localparam logic [63:0] DEFAULT_N0 [DEFAULT_N] = '{
        64'hFFFF_FFFF_FFFF_FFFF,
        64'h5555_5555_5555_5555,
        64'h3333_3333_3333_3333,
        64'h9249_2492_4924_9249
    };

    function automatic logic [63:0] two_minus(input logic [63:0] t);
        return 64'd2 - t;
    endfunction

endpackage

// File: rtl/mod_table_rw_mont_n0_engine.sv
// Sequential Newton/Hensel engine computing n0' = -m^-1 mod 2^64 with one
// shared 64x64 low-half multiplier.
//
//  state  | meaning
//  IDLE   | ready for a new request
//  ERR    | request rejected, err pulse out
//  MUL_A  | t = m*x
//  MUL_B  | x = x*(2-t), count down iterations
//  COMMIT | done pulse, n0 valid
module mont_n0_engine
    import mod_table_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_reject,
    input  logic [63:0] i_m,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_err,
    output logic [63:0] o_n0
);

    n0_state_e   r_state;
    logic        r_ready;
    logic        r_done;
    logic        r_err;
    logic [2:0]  r_iter;
    logic [63:0] r_m;
    logic [63:0] r_x;
    logic [63:0] r_t;

    logic [63:0] w_op_a;
    logic [63:0] w_op_b;
    logic [63:0] w_prod;

    always_comb begin
        w_op_a = r_x;
        w_op_b = two_minus(r_t);
        if (r_state == MUL_A) begin
            w_op_a = r_m;
            w_op_b = r_x;
        end
        w_prod = w_op_a * w_op_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_iter  <= 3'd0;
            r_m     <= 64'd0;
            r_x     <= 64'd0;
            r_t     <= 64'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_ready <= 1'b0;
                        if (i_reject) begin
                            r_err   <= 1'b1;
                            r_state <= ERR;
                        end else begin
                            r_m     <= i_m;
                            r_x     <= i_m;
                            r_iter  <= 3'(NEWTON_ITERS - 1);
                            r_state <= MUL_A;
                        end
                    end
                end
                ERR: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                MUL_A: begin
                    r_t     <= w_prod;
                    r_state <= MUL_B;
                end
                MUL_B: begin
                    r_x <= w_prod;
                    if (r_iter == 3'd0) begin
                        r_done  <= 1'b1;
                        r_state <= COMMIT;
                    end else begin
                        r_iter  <= r_iter - 3'd1;
                        r_state <= MUL_A;
                    end
                end
                COMMIT: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_n0    = 64'd0 - r_x;

endmodule

// File: rtl/mod_table_rw.sv
// Runtime-writable RNS modulus table with Montgomery n0' per entry and
// NUM_RD registered read ports. MOD_TABLE_DEFAULT_INIT_EN preloads defaults.
module mod_table_rw
    import mod_table_pkg::*;
#(
    parameter int MOD_W  = 50,
    parameter int DEPTH  = 64,
    parameter int NUM_RD = 4,
    parameter int ID_W   = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wr_valid,
    output logic                   o_wr_ready,
    input  logic [ID_W-1:0]        i_wr_id,
    input  logic [MOD_W-1:0]       i_wr_modulus,
    output logic                   o_wr_done,
    output logic                   o_wr_err,
    input  logic                   i_clr_valid,
    input  logic [ID_W-1:0]        i_clr_id,
    input  logic [NUM_RD*ID_W-1:0] i_rd_id,
    output logic [NUM_RD*64-1:0]   o_rd_modulus,
    output logic [NUM_RD*64-1:0]   o_rd_modulus_inv,
    output logic [NUM_RD-1:0]      o_rd_hit
);

    localparam logic [ID_W:0] DEPTH_X = (ID_W+1)'(DEPTH);

    logic [63:0]       r_mod_mem [DEPTH];
    logic [63:0]       r_inv_mem [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [ID_W-1:0]   r_wr_id;
    logic [63:0]       r_wr_mod;

    logic [NUM_RD*64-1:0] r_rd_mod;
    logic [NUM_RD*64-1:0] r_rd_inv;
    logic [NUM_RD-1:0]    r_rd_hit;

    logic              w_ready;
    logic              w_done;
    logic              w_err;
    logic [63:0]       w_n0;
    logic              w_accept;
    logic              w_bad;
    logic              w_clr_ok;
    logic [ID_W-1:0]   w_rd_idx [NUM_RD];
    logic [NUM_RD-1:0] w_rd_hit;

    // Odd check also rejects zero.
    assign w_accept = i_wr_valid & w_ready;
    assign w_bad    = ~i_wr_modulus[0] | ({1'b0, i_wr_id} >= DEPTH_X);
    assign w_clr_ok = i_clr_valid & ({1'b0, i_clr_id} < DEPTH_X);

    mont_n0_engine u_engine (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_accept),
        .i_reject (w_bad),
        .i_m      (64'(i_wr_modulus)),
        .o_ready  (w_ready),
        .o_done   (w_done),
        .o_err    (w_err),
        .o_n0     (w_n0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_id  <= '0;
            r_wr_mod <= 64'd0;
        end else if (w_accept) begin
            r_wr_id  <= i_wr_id;
            r_wr_mod <= 64'(i_wr_modulus);
        end
    end

    // Commit is applied after the clear so it wins on a same-id collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
`ifdef MOD_TABLE_DEFAULT_INIT_EN
            for (int i = 0; i < DEFAULT_N; i++) begin
                r_valid[i] <= 1'b1;
            end
`endif
        end else begin
            if (w_clr_ok) begin
                r_valid[i_clr_id] <= 1'b0;
            end
            if (w_done) begin
                r_valid[r_wr_id] <= 1'b1;
            end
        end
    end

`ifdef MOD_TABLE_DEFAULT_INIT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mod_mem[i] <= 64'd0;
                r_inv_mem[i] <= 64'd0;
            end
            for (int i = 0; i < DEFAULT_N; i++) begin
                r_mod_mem[i] <= DEFAULT_MOD[i];
                r_inv_mem[i] <= DEFAULT_N0[i];
            end
        end else if (w_done) begin
            r_mod_mem[r_wr_id] <= r_wr_mod;
            r_inv_mem[r_wr_id] <= w_n0;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (w_done) begin
            r_mod_mem[r_wr_id] <= r_wr_mod;
            r_inv_mem[r_wr_id] <= w_n0;
        end
    end
`endif

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            w_rd_idx[k] = i_rd_id[k*ID_W +: ID_W];
            w_rd_hit[k] = ({1'b0, w_rd_idx[k]} < DEPTH_X) && r_valid[w_rd_idx[k]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_mod <= '0;
            r_rd_inv <= '0;
            r_rd_hit <= '0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                if (w_rd_hit[k]) begin
                    r_rd_mod[k*64 +: 64] <= r_mod_mem[w_rd_idx[k]];
                    r_rd_inv[k*64 +: 64] <= r_inv_mem[w_rd_idx[k]];
                end else begin
                    r_rd_mod[k*64 +: 64] <= 64'd0;
                    r_rd_inv[k*64 +: 64] <= 64'd0;
                end
            end
            r_rd_hit <= w_rd_hit;
        end
    end

    assign o_wr_ready       = w_ready;
    assign o_wr_done        = w_done;
    assign o_wr_err         = w_err;
    assign o_rd_modulus     = r_rd_mod;
    assign o_rd_modulus_inv = r_rd_inv;
    assign o_rd_hit         = r_rd_hit;

endmodule

// File: tb/tb_mod_table_rw.sv
// Directed bench for mod_table_rw with DEPTH=48 so out-of-range ids are reachable.
module tb_mod_table_rw;

    localparam int MOD_W  = 50;
    localparam int DEPTH  = 48;
    localparam int NUM_RD = 4;
    localparam int ID_W   = 6;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   i_wr_valid = 1'b0;
    logic                   o_wr_ready;
    logic [ID_W-1:0]        i_wr_id = '0;
    logic [MOD_W-1:0]       i_wr_modulus = '0;
    logic                   o_wr_done;
    logic                   o_wr_err;
    logic                   i_clr_valid = 1'b0;
    logic [ID_W-1:0]        i_clr_id = '0;
    logic [NUM_RD*ID_W-1:0] i_rd_id = '0;
    logic [NUM_RD*64-1:0]   o_rd_modulus;
    logic [NUM_RD*64-1:0]   o_rd_modulus_inv;
    logic [NUM_RD-1:0]      o_rd_hit;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] rand_m;

    always #5 clk = ~clk;

    mod_table_rw #(.MOD_W(MOD_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ID_W(ID_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_wr_valid       (i_wr_valid),
        .o_wr_ready       (o_wr_ready),
        .i_wr_id          (i_wr_id),
        .i_wr_modulus     (i_wr_modulus),
        .o_wr_done        (o_wr_done),
        .o_wr_err         (o_wr_err),
        .i_clr_valid      (i_clr_valid),
        .i_clr_id         (i_clr_id),
        .i_rd_id          (i_rd_id),
        .o_rd_modulus     (o_rd_modulus),
        .o_rd_modulus_inv (o_rd_modulus_inv),
        .o_rd_hit         (o_rd_hit)
    );

    // Issues one write and records, in cycles after acceptance, the first
    // done / err / ready observation (-1 if never seen in 14 cycles).
    task automatic do_write(input logic [ID_W-1:0] id, input logic [63:0] m,
                            output int done_cyc, output int err_cyc, output int rdy_cyc);
        done_cyc = -1; err_cyc = -1; rdy_cyc = -1;
        @(negedge clk);
        i_wr_valid = 1'b1; i_wr_id = id; i_wr_modulus = m[MOD_W-1:0];
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            i_wr_valid = 1'b0;
            if (o_wr_done === 1'b1 && done_cyc < 0) done_cyc = j;
            if (o_wr_err === 1'b1 && err_cyc < 0) err_cyc = j;
            if (o_wr_ready === 1'b1 && rdy_cyc < 0) rdy_cyc = j;
        end
    endtask

    task automatic read_port(input int k, input logic [ID_W-1:0] id,
                             output logic [63:0] m, output logic [63:0] inv, output logic hit);
        @(negedge clk);
        i_rd_id[k*ID_W +: ID_W] = id;
        @(negedge clk);
        m   = o_rd_modulus[k*64 +: 64];
        inv = o_rd_modulus_inv[k*64 +: 64];
        hit = o_rd_hit[k];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (o_wr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b expected 1", o_wr_ready); end
        n_cmp++; if (o_wr_done !== 1'b0 || o_wr_err !== 1'b0) begin n_bad++; $display("FAIL rst_pulses: got done=%b err=%b expected 0/0", o_wr_done, o_wr_err); end
        n_cmp++; if (o_rd_hit !== '0 || o_rd_modulus !== '0 || o_rd_modulus_inv !== '0) begin n_bad++; $display("FAIL rst_rd: got hit=%b expected 0 with zero data", o_rd_hit); end
        rst_n = 1'b1;
        i_rd_id = {6'd3, 6'd2, 6'd1, 6'd0};
        @(negedge clk);
        n_cmp++; if (o_rd_hit !== 4'b0000) begin n_bad++; $display("FAIL rst_read_hit: got %b expected 0000", o_rd_hit); end
        n_cmp++; if (o_rd_modulus !== '0 || o_rd_modulus_inv !== '0) begin n_bad++; $display("FAIL rst_read_data: got %h expected 0", o_rd_modulus); end
        n_cmp++; if (o_wr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b expected 1", o_wr_ready); end
    endtask

    task automatic test_write();
        int d, e, r;
        logic [63:0] m, inv;
        logic hit;
        do_write(6'd5, 64'd3, d, e, r);
        n_cmp++; if (d !== 11) begin n_bad++; $display("FAIL wr_done_cycle: got %0d expected 11", d); end
        n_cmp++; if (e !== -1) begin n_bad++; $display("FAIL wr_no_err: got %0d expected -1", e); end
        n_cmp++; if (r !== 12) begin n_bad++; $display("FAIL wr_ready_cycle: got %0d expected 12", r); end
        read_port(0, 6'd5, m, inv, hit);
        n_cmp++; if (m !== 64'd3 || inv !== 64'h5555_5555_5555_5555 || hit !== 1'b1) begin
            n_bad++; $display("FAIL wr_read5: got m=%h inv=%h hit=%b expected 3/5555555555555555/1", m, inv, hit); end
    endtask

    task automatic test_inverse();
        int d, e, r;
        logic [63:0] m, inv, chk;
        logic hit;
        do_write(6'd7, 64'd1, d, e, r);
        read_port(1, 6'd7, m, inv, hit);
        n_cmp++; if (m !== 64'd1 || inv !== 64'hFFFF_FFFF_FFFF_FFFF || hit !== 1'b1) begin
            n_bad++; $display("FAIL inv_m1: got m=%h inv=%h hit=%b expected 1/ffffffffffffffff/1", m, inv, hit); end
        for (int n = 0; n < 3; n++) begin
            rand_m = {$urandom(), $urandom()};
            rand_m[63:50] = '0;
            rand_m[0] = 1'b1;
            do_write(6'd9, rand_m, d, e, r);
            read_port(2, 6'd9, m, inv, hit);
            chk = m * inv + 64'd1;
            n_cmp++; if (m !== rand_m || chk !== 64'd0 || hit !== 1'b1) begin
                n_bad++; $display("FAIL inv_rand: got m=%h inv=%h m*inv+1=%h expected m=%h and 0", m, inv, chk, rand_m); end
        end
        @(negedge clk);
        i_rd_id = {6'd5, 6'd9, 6'd7, 6'd5};
        @(negedge clk);
        n_cmp++; if (o_rd_hit !== 4'b1111) begin n_bad++; $display("FAIL multi_hit: got %b expected 1111", o_rd_hit); end
        n_cmp++; if (o_rd_modulus[0 +: 64] !== 64'd3 || o_rd_modulus[64 +: 64] !== 64'd1 ||
                     o_rd_modulus[128 +: 64] !== rand_m || o_rd_modulus[192 +: 64] !== 64'd3) begin
            n_bad++; $display("FAIL multi_mod: got %h expected ports 3/1/%h/3", o_rd_modulus, rand_m); end
        n_cmp++; if (o_rd_modulus_inv[192 +: 64] !== 64'h5555_5555_5555_5555) begin
            n_bad++; $display("FAIL multi_inv3: got %h expected 5555555555555555", o_rd_modulus_inv[192 +: 64]); end
    endtask

    task automatic test_reject();
        int d, e, r;
        logic [63:0] m, inv;
        logic hit;
        do_write(6'd10, 64'd4, d, e, r);
        n_cmp++; if (e !== 1 || d !== -1 || r !== 2) begin
            n_bad++; $display("FAIL rej_even: got err=%0d done=%0d rdy=%0d expected 1/-1/2", e, d, r); end
        do_write(6'(DEPTH), 64'd3, d, e, r);
        n_cmp++; if (e !== 1 || d !== -1 || r !== 2) begin
            n_bad++; $display("FAIL rej_id: got err=%0d done=%0d rdy=%0d expected 1/-1/2", e, d, r); end
        do_write(6'd11, 64'd0, d, e, r);
        n_cmp++; if (e !== 1 || d !== -1) begin
            n_bad++; $display("FAIL rej_zero: got err=%0d done=%0d expected 1/-1", e, d); end
        read_port(0, 6'd5, m, inv, hit);
        n_cmp++; if (m !== 64'd3 || inv !== 64'h5555_5555_5555_5555 || hit !== 1'b1) begin
            n_bad++; $display("FAIL rej_keep5: got m=%h inv=%h hit=%b expected 3/5555555555555555/1", m, inv, hit); end
        read_port(0, 6'd10, m, inv, hit);
        n_cmp++; if (hit !== 1'b0 || m !== 64'd0) begin n_bad++; $display("FAIL rej_id10: got hit=%b m=%h expected 0/0", hit, m); end
        read_port(0, 6'(DEPTH), m, inv, hit);
        n_cmp++; if (hit !== 1'b0 || m !== 64'd0 || inv !== 64'd0) begin
            n_bad++; $display("FAIL rd_oor: got hit=%b m=%h expected 0/0", hit, m); end
    endtask

    task automatic test_atomic();
        logic [63:0] exp_m, exp_inv;
        @(negedge clk);
        i_rd_id[0 +: ID_W] = 6'd5;
        i_wr_valid = 1'b1; i_wr_id = 6'd5; i_wr_modulus = 50'd5;
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
            i_wr_valid = 1'b0;
            exp_m   = (j <= 12) ? 64'd3 : 64'd5;
            exp_inv = (j <= 12) ? 64'h5555_5555_5555_5555 : 64'h3333_3333_3333_3333;
            n_cmp++; if (o_rd_modulus[0 +: 64] !== exp_m || o_rd_modulus_inv[0 +: 64] !== exp_inv || o_rd_hit[0] !== 1'b1) begin
                n_bad++; $display("FAIL atomic_j%0d: got m=%h inv=%h hit=%b expected %h/%h/1", j,
                                  o_rd_modulus[0 +: 64], o_rd_modulus_inv[0 +: 64], o_rd_hit[0], exp_m, exp_inv); end
        end
    endtask

    task automatic test_clear();
        logic [63:0] m, inv;
        logic hit;
        @(negedge clk);
        i_clr_valid = 1'b1; i_clr_id = 6'd7;
        @(negedge clk);
        i_clr_valid = 1'b0;
        read_port(1, 6'd7, m, inv, hit);
        n_cmp++; if (hit !== 1'b0 || m !== 64'd0) begin n_bad++; $display("FAIL clr_alone: got hit=%b m=%h expected 0/0", hit, m); end
        @(negedge clk);
        i_clr_valid = 1'b1; i_clr_id = 6'(DEPTH);
        @(negedge clk);
        i_clr_valid = 1'b0;
        read_port(2, 6'd9, m, inv, hit);
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL clr_oor: got hit=%b expected 1", hit); end
        @(negedge clk);
        i_wr_valid = 1'b1; i_wr_id = 6'd5; i_wr_modulus = 50'd3;
        for (int j = 1; j <= 13; j++) begin
            @(negedge clk);
            i_wr_valid = 1'b0;
            i_clr_valid = 1'b0;
            if (j == 11) begin
                n_cmp++; if (o_wr_done !== 1'b1) begin n_bad++; $display("FAIL clr_commit_done: got %b expected 1", o_wr_done); end
                i_clr_valid = 1'b1; i_clr_id = 6'd5;
            end
        end
        read_port(0, 6'd5, m, inv, hit);
        n_cmp++; if (hit !== 1'b1 || m !== 64'd3 || inv !== 64'h5555_5555_5555_5555) begin
            n_bad++; $display("FAIL clr_vs_commit: got hit=%b m=%h inv=%h expected 1/3/5555555555555555", hit, m, inv); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] m, inv;
        logic hit;
        @(negedge clk);
        i_wr_valid = 1'b1; i_wr_id = 6'd9; i_wr_modulus = 50'd11;
        @(negedge clk);
        i_wr_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        n_cmp++; if (o_wr_ready !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b expected 0", o_wr_ready); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (o_wr_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b expected 1", o_wr_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            n_cmp++; if (o_wr_done !== 1'b0) begin n_bad++; $display("FAIL mid_no_done_%0d: got %b expected 0", j, o_wr_done); end
        end
        read_port(2, 6'd9, m, inv, hit);
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL mid_entry9: got hit=%b expected 0", hit); end
        read_port(0, 6'd5, m, inv, hit);
        n_cmp++; if (hit !== 1'b0) begin n_bad++; $display("FAIL mid_entry5: got hit=%b expected 0", hit); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_inverse();
        test_reject();
        test_atomic();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
